// File: rtl/psys_wide_stream_arbiter.sv
// Packet-locked round-robin arbiter feeding one wide AXI-Stream downconverter.
// Define PSYS_ARB_PRIO_EN to make source 0 strict high priority at packet boundaries.
module psys_wide_stream_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 1536,
    parameter int LAST_W  = DATA_W / 128,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC*DATA_W-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]          s_axis_tvalid,
    output logic [NUM_SRC-1:0]          s_axis_tready,
    input  logic [NUM_SRC*LAST_W-1:0]   s_axis_tlast,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [LAST_W-1:0]           m_axis_tlast,
    output logic [ID_W-1:0]             m_axis_tid,
    output logic                        busy
);

    // Handshake: a beat transfers on a rising clk edge where valid & ready are both high;
    // valid never waits on ready, and payload is held stable while valid & ~ready.
    typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
    logic [LAST_W-1:0]   m_tlast_q, m_tlast_d;
    logic [ID_W-1:0]     m_tid_q, m_tid_d;
    logic                m_tvalid_q, m_tvalid_d;

    logic [DATA_W-1:0]   src_data;
    logic [LAST_W-1:0]   src_last;
    logic                out_room;
    logic                accept;
    logic [ID_W:0]       rr;
    logic                pick_valid;
    logic [ID_W-1:0]     pick_idx;

    // Returns {found, index} of the first requester after 'last', wrapping.
    function automatic logic [ID_W:0] rr_pick(input logic [ID_W-1:0] last,
                                              input logic [NUM_SRC-1:0] req);
        logic [ID_W:0] res;
        int            cand;
        res = '0;
        for (int off = NUM_SRC; off >= 1; off--) begin
            cand = (int'(last) + off) % NUM_SRC;
            if (req[cand[ID_W-1:0]]) res = {1'b1, cand[ID_W-1:0]};
        end
        return res;
    endfunction

    always_comb begin
        rr         = '0;
        pick_valid = 1'b0;
        pick_idx   = '0;
`ifdef PSYS_ARB_PRIO_EN
        rr         = rr_pick(last_grant_q, s_axis_tvalid & ~NUM_SRC'(1));
        pick_valid = s_axis_tvalid[0] | rr[ID_W];
        pick_idx   = s_axis_tvalid[0] ? '0 : rr[ID_W-1:0];
`else
        rr         = rr_pick(last_grant_q, s_axis_tvalid);
        pick_valid = rr[ID_W];
        pick_idx   = rr[ID_W-1:0];
`endif
    end

    assign src_data = s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W];
    assign src_last = s_axis_tlast[int'(grant_q)*LAST_W +: LAST_W];
    assign out_room = ~m_tvalid_q | m_axis_tready;

    always_comb begin
        s_axis_tready = '0;
        if (state_q == ST_LOCK) s_axis_tready[grant_q] = out_room;
    end

    assign accept = (state_q == ST_LOCK) & s_axis_tvalid[grant_q] & out_room;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_tdata_d    = m_tdata_q;
        m_tlast_d    = m_tlast_q;
        m_tid_d      = m_tid_q;
        m_tvalid_d   = m_tvalid_q;

        if (m_tvalid_q & m_axis_tready) m_tvalid_d = 1'b0;
        // A new accept overrides the drain so back-to-back beats keep valid high.
        if (accept) begin
            m_tdata_d  = src_data;
            m_tlast_d  = src_last;
            m_tid_d    = grant_q;
            m_tvalid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (accept && (|src_last)) begin
                    state_d = ST_IDLE;
`ifdef PSYS_ARB_PRIO_EN
                    if (grant_q != '0) last_grant_d = grant_q;
`else
                    last_grant_d = grant_q;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_SRC - 1);
            m_tdata_q    <= '0;
            m_tlast_q    <= '0;
            m_tid_q      <= '0;
            m_tvalid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            m_tdata_q    <= m_tdata_d;
            m_tlast_q    <= m_tlast_d;
            m_tid_q      <= m_tid_d;
            m_tvalid_q   <= m_tvalid_d;
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tid    = m_tid_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign busy          = (state_q == ST_LOCK);

endmodule

// File: tb/tb_psys_wide_stream_arbiter.sv
// Directed bench for psys_wide_stream_arbiter: per-source beat lists, expected-beat queue,
// per-cycle handshake/stability checks.
module tb_psys_wide_stream_arbiter;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 1536;
    localparam int LAST_W  = 12;
    localparam int ID_W    = 2;
    localparam int REP     = DATA_W / 16;
    localparam int EW      = ID_W + LAST_W + 16;

    logic                        clk;
    logic                        rst_n;
    logic [NUM_SRC*DATA_W-1:0]   s_axis_tdata;
    logic [NUM_SRC-1:0]          s_axis_tvalid;
    logic [NUM_SRC-1:0]          s_axis_tready;
    logic [NUM_SRC*LAST_W-1:0]   s_axis_tlast;
    logic [DATA_W-1:0]           m_axis_tdata;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic [LAST_W-1:0]           m_axis_tlast;
    logic [ID_W-1:0]             m_axis_tid;
    logic                        busy;

    psys_wide_stream_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tid    (m_axis_tid),
        .busy          (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0]       src_tag  [NUM_SRC][8];
    logic [LAST_W-1:0] src_last [NUM_SRC][8];
    int                src_cnt  [NUM_SRC];
    int                src_ptr  [NUM_SRC];

    logic [EW-1:0]     exp_q[$];

    int                cyc = 0;
    int                t0 = 0;
    int                stall_from = 0;
    int                stall_len = 0;
    bit                sb_en = 1'b1;
    bit                spacing_en = 1'b0;
    int                spacing_exp = 1;
    int                last_fire_cyc = -1;
    int                first_valid_cyc = -1;
    bit                prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [LAST_W-1:0] prev_last;
    logic [ID_W-1:0]   prev_tid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic add_beat(input int s, input logic [15:0] tag, input logic [LAST_W-1:0] last);
        src_tag[s][src_cnt[s]]  = tag;
        src_last[s][src_cnt[s]] = last;
        src_cnt[s]++;
    endtask

    task automatic push_exp(input logic [ID_W-1:0] tid, input logic [15:0] tag,
                            input logic [LAST_W-1:0] last);
        exp_q.push_back({tid, last, tag});
    endtask

    task automatic drive();
        for (int s = 0; s < NUM_SRC; s++) begin
            if (src_ptr[s] < src_cnt[s]) begin
                s_axis_tvalid[s]                  = 1'b1;
                s_axis_tdata[s*DATA_W +: DATA_W]  = {REP{src_tag[s][src_ptr[s]]}};
                s_axis_tlast[s*LAST_W +: LAST_W]  = src_last[s][src_ptr[s]];
            end else begin
                s_axis_tvalid[s]                  = 1'b0;
                s_axis_tdata[s*DATA_W +: DATA_W]  = '0;
                s_axis_tlast[s*LAST_W +: LAST_W]  = '0;
            end
        end
    endtask

    task automatic step();
        logic [NUM_SRC-1:0] fire;
        logic               out_fire;
        logic [EW-1:0]      e;
        fire     = s_axis_tvalid & s_axis_tready & {NUM_SRC{rst_n}};
        out_fire = rst_n && m_axis_tvalid && m_axis_tready;
        check("ready_onehot0", 64'($onehot0(s_axis_tready)), 64'd1);
        if (prev_stall && rst_n) begin
            check("hold_data", 64'(m_axis_tdata == prev_data), 64'd1);
            check("hold_last", 64'(m_axis_tlast), 64'(prev_last));
            check("hold_tid",  64'(m_axis_tid), 64'(prev_tid));
        end
        if (m_axis_tvalid && !m_axis_tready) check("stall_ready", 64'(s_axis_tready), 64'd0);
        // scoreboard
        if (out_fire && sb_en) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_tid",  64'(m_axis_tid), 64'(e[EW-1 -: ID_W]));
                check("out_last", 64'(m_axis_tlast), 64'(e[16 +: LAST_W]));
                check("out_data", 64'(m_axis_tdata == {REP{e[15:0]}}), 64'd1);
                if (spacing_en && last_fire_cyc >= 0)
                    check("fire_spacing", 64'(cyc - last_fire_cyc), 64'(spacing_exp));
                last_fire_cyc = cyc;
            end
        end
        if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
        prev_stall = rst_n && m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        prev_tid   = m_axis_tid;
        @(posedge clk);
        #1;
        cyc++;
        for (int s = 0; s < NUM_SRC; s++) if (fire[s]) src_ptr[s]++;
        m_axis_tready = !((cyc - t0) >= stall_from && (cyc - t0) < stall_from + stall_len);
        drive();
        #1;
    endtask

    function automatic bit all_done();
        for (int s = 0; s < NUM_SRC; s++) if (src_ptr[s] != src_cnt[s]) return 1'b0;
        return (exp_q.size() == 0) && !m_axis_tvalid && !busy;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            src_cnt[s] = 0;
            src_ptr[s] = 0;
        end
        drive();
        m_axis_tready = 1'b1;
        stall_len     = 0;
        spacing_en    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        prev_stall      = 1'b0;
        last_fire_cyc   = -1;
        first_valid_cyc = -1;
        sb_en           = 1'b1;
        #1;
    endtask

    task automatic run_test(input string name, input int budget);
        drive();
        t0 = cyc;
        for (int i = 0; i < budget && !all_done(); i++) step();
        check({name, "_drained"}, 64'(all_done()), 64'd1);
        check({name, "_exp_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b1;
        do_reset();

        // reset state
        check("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_mdata",  64'(m_axis_tdata == '0), 64'd1);
        check("rst_mlast",  64'(m_axis_tlast), 64'd0);
        check("rst_mtid",   64'(m_axis_tid), 64'd0);
        check("rst_sready", 64'(s_axis_tready), 64'd0);
        check("rst_busy",   64'(busy), 64'd0);

        // src1 3-beat packet: 2-cycle latency, back-to-back output
        add_beat(1, 16'h1100, 12'h000);
        add_beat(1, 16'h1101, 12'h000);
        add_beat(1, 16'h1102, 12'h800);
        push_exp(2'd1, 16'h1100, 12'h000);
        push_exp(2'd1, 16'h1101, 12'h000);
        push_exp(2'd1, 16'h1102, 12'h800);
        spacing_en  = 1'b1;
        spacing_exp = 1;
        run_test("t1", 40);
        check("t1_latency", 64'(first_valid_cyc - t0), 64'd2);
        check("t1_idle", 64'(busy), 64'd0);

        // all sources request: round-robin 0,1,2,3,0 at packet granularity
        do_reset();
        for (int s = 0; s < NUM_SRC; s++) begin
            add_beat(s, 16'(16'h2000 + s*16), 12'h000);
            add_beat(s, 16'(16'h2001 + s*16), 12'h001);
        end
        add_beat(0, 16'h2002, 12'h000);
        add_beat(0, 16'h2003, 12'h001);
        for (int s = 0; s < NUM_SRC; s++) begin
            push_exp(ID_W'(s), 16'(16'h2000 + s*16), 12'h000);
            push_exp(ID_W'(s), 16'(16'h2001 + s*16), 12'h001);
        end
        push_exp(2'd0, 16'h2002, 12'h000);
        push_exp(2'd0, 16'h2003, 12'h001);
        run_test("t2", 80);

        // src2 packet with a 5-cycle converter stall in the middle
        do_reset();
        for (int b = 0; b < 4; b++) begin
            add_beat(2, 16'(16'h3020 + b), (b == 3) ? 12'h010 : 12'h000);
            push_exp(2'd2, 16'(16'h3020 + b), (b == 3) ? 12'h010 : 12'h000);
        end
        stall_from = 3;
        stall_len  = 5;
        run_test("t3", 60);
        stall_len  = 0;

        // single-beat packets alternating src0/src3, one packet every 2 cycles
        do_reset();
        add_beat(0, 16'h4000, 12'h001);
        add_beat(0, 16'h4001, 12'h001);
        add_beat(3, 16'h4030, 12'h001);
        add_beat(3, 16'h4031, 12'h001);
        push_exp(2'd0, 16'h4000, 12'h001);
        push_exp(2'd3, 16'h4030, 12'h001);
        push_exp(2'd0, 16'h4001, 12'h001);
        push_exp(2'd3, 16'h4031, 12'h001);
        spacing_en  = 1'b1;
        spacing_exp = 2;
        run_test("t4", 60);

        // reset in the middle of a src1 packet
        do_reset();
        sb_en = 1'b0;
        for (int b = 0; b < 4; b++) add_beat(1, 16'(16'h5010 + b), (b == 3) ? 12'h001 : 12'h000);
        add_beat(3, 16'h5030, 12'h001);
        drive();
        t0 = cyc;
        step();
        step();
        step();
        check("t5_pre_mvalid", 64'(m_axis_tvalid), 64'd1);
        rst_n = 1'b0;
        step();
        check("t5_rst_mvalid", 64'(m_axis_tvalid), 64'd0);
        check("t5_rst_busy",   64'(busy), 64'd0);
        check("t5_rst_sready", 64'(s_axis_tready), 64'd0);
        rst_n = 1'b1;
        step();
        check("t5_regrant_busy", 64'(busy), 64'd1);
        step();
        step();
        check("t5_regrant_mvalid", 64'(m_axis_tvalid), 64'd1);
        check("t5_regrant_tid",    64'(m_axis_tid), 64'd1);

        // src0 and src2 competing from a fresh reset
        do_reset();
        add_beat(0, 16'h6000, 12'h001);
        add_beat(0, 16'h6001, 12'h001);
        add_beat(2, 16'h6020, 12'h001);
`ifdef PSYS_ARB_PRIO_EN
        push_exp(2'd0, 16'h6000, 12'h001);
        push_exp(2'd0, 16'h6001, 12'h001);
        push_exp(2'd2, 16'h6020, 12'h001);
`else
        push_exp(2'd0, 16'h6000, 12'h001);
        push_exp(2'd2, 16'h6020, 12'h001);
        push_exp(2'd0, 16'h6001, 12'h001);
`endif
        run_test("t6", 40);

        // final report
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
